// File: rtl/udt_connect.sv
// rtl/udt_connect.sv - UDT caller-side two-phase handshake initiator
// Purpose: drives the request/response handshake against a UDT listener,
//   with per-request timeout, full-handshake retries and final status.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, close               control pulses from the socket layer
//   client_type_en/_type/_cookie  one-cycle request strobe to the listener
//   serve_type_en/_type/_cookie   listener response
//   busy, connected, fail      status levels
//   retry_cnt                  restarts taken in the current attempt
module udt_connect #(
  parameter int TIMEOUT   = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             close,
  output logic                             client_type_en,
  output logic [31:0]                      client_type,
  output logic [31:0]                      client_cookie,
  input  logic                             serve_type_en,
  input  logic [31:0]                      serve_type,
  input  logic [31:0]                      serve_cookie,
  output logic                             busy,
  output logic                             connected,
  output logic                             fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [31:0]   TYPE_PH1   = 32'h0000_0000;
  localparam logic [31:0]   TYPE_RSP1  = 32'h0000_0001;
  localparam logic [31:0]   TYPE_PH2   = 32'hFFFF_FFFF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ1  = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_REQ2  = 3'd3;
  localparam logic [2:0] S_WAIT2 = 3'd4;
  localparam logic [2:0] S_RETRY = 3'd5;
  localparam logic [2:0] S_CONN  = 3'd6;
  localparam logic [2:0] S_FAIL  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   cookie_q, cookie_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          en_q, en_d;
  logic [31:0]   type_q, type_d;
  logic [31:0]   ck_out_q, ck_out_d;
  logic          busy_q, busy_d;
  logic          conn_q, conn_d;
  logic          fail_q, fail_d;

  logic rsp1_ok, rsp2_ok, timed_out;

  assign rsp1_ok   = serve_type_en && (serve_type == TYPE_RSP1);
  assign rsp2_ok   = serve_type_en && (serve_type == TYPE_PH2);
  assign timed_out = (timer_q == TIMER_LAST);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cookie_d = cookie_q;
    retry_d  = retry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_REQ1;
          retry_d  = '0;
          cookie_d = '0;
        end
      end
      S_REQ1: begin
        state_d = S_WAIT1;
        timer_d = '0;
      end
      S_WAIT1: begin
        // A valid response wins even on the final wait cycle.
        if (rsp1_ok) begin
          cookie_d = serve_cookie;
          state_d  = S_REQ2;
        end else if (timed_out) begin
          state_d = S_RETRY;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_REQ2: begin
        state_d = S_WAIT2;
        timer_d = '0;
      end
      S_WAIT2: begin
        if (rsp2_ok) begin
          state_d = S_CONN;
        end else if (timed_out) begin
          state_d = S_RETRY;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RETRY: begin
        if (retry_q == RETRY_LAST) begin
          state_d = S_FAIL;
        end else begin
          retry_d  = retry_q + 1'b1;
          cookie_d = '0;
          state_d  = S_REQ1;
        end
      end
      S_CONN: begin
        if (close) begin
          state_d = S_IDLE;
          retry_d = '0;
        end
      end
      S_FAIL: begin
        if (close || start) begin
          state_d = S_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The phase-1 strobe is launched as REQ1 is entered; the phase-2 strobe is
  // launched while leaving REQ2 so it carries the cookie captured one cycle
  // earlier.
  always_comb begin
    en_d     = (state_d == S_REQ1) || (state_q == S_REQ2);
    type_d   = (state_q == S_REQ2) ? TYPE_PH2 : TYPE_PH1;
    ck_out_d = (state_q == S_REQ2) ? cookie_q : 32'h0;
    busy_d   = (state_d != S_IDLE) && (state_d != S_CONN) && (state_d != S_FAIL);
    conn_d   = (state_d == S_CONN);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cookie_q <= '0;
      retry_q  <= '0;
      en_q     <= 1'b0;
      type_q   <= '0;
      ck_out_q <= '0;
      busy_q   <= 1'b0;
      conn_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cookie_q <= cookie_d;
      retry_q  <= retry_d;
      en_q     <= en_d;
      type_q   <= type_d;
      ck_out_q <= ck_out_d;
      busy_q   <= busy_d;
      conn_q   <= conn_d;
      fail_q   <= fail_d;
    end
  end

  assign client_type_en = en_q;
  assign client_type    = type_q;
  assign client_cookie  = ck_out_q;
  assign busy           = busy_q;
  assign connected      = conn_q;
  assign fail           = fail_q;
  assign retry_cnt      = retry_q;

endmodule
